// File: rtl/mult_pkg.sv
// Shared constants for the MULT/MULTU sequencer: FSM state codes, default
// operand width, and the op encoding carried on the is_signed input.
// Pure declarations; no logic, no latency, no flow control.
package mult_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_CNT_W = 5;

  // FSM state codes, kept as plain constants so the state register stays a
  // simple logic vector for older tooling.
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t CALC  = 2'd1;
  localparam state_t FIXUP = 2'd2;

  // Op encoding matches the is_signed bit directly.
  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_MULT  = 1'b1;

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration: conditionally add multiplicand to the upper half,
// then shift {carry, product} right by one. Purely combinational, zero latency,
// no handshake.
// Ports: prod_i current product, mcand_i multiplicand magnitude,
//        lsb_i current multiplier LSB, prod_o next shifted product.
module mult_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] prod_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic               lsb_i,
  output logic [2*WIDTH-1:0] prod_o
);

  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] ext;

  // sum carries one extra bit so the add-out lands in the top of the shift.
  assign sum    = {1'b0, prod_i[2*WIDTH-1:WIDTH]} + {1'b0, (lsb_i ? mcand_i : {WIDTH{1'b0}})};
  assign ext    = {sum, prod_i[WIDTH-1:0]};
  assign prod_o = (2*WIDTH)'(ext >> 1);

endmodule

// File: rtl/mult_sequencer.sv
// MULT/MULTU controller and owner of the architectural HI/LO registers.
// Latency: start at edge T -> result in HI/LO and done pulse after edge T+WIDTH+1.
// Backpressure: busy stalls the execute stage; start/MTHI/MTLO ignored while busy.
// Ports: clk, rst_n (async active-low); start/is_signed/multiplicand/multiplier
//        launch a multiply from IDLE; cancel aborts an in-flight one;
//        hi_we/lo_we/wdata are MTHI/MTLO writes (IDLE only);
//        busy, done (1-cycle pulse), hi, lo are outputs.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = MULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] step_prod;

  // Magnitudes for signed ops. The most negative value negates to itself,
  // which read as unsigned is exactly its magnitude.
  assign a_mag = (is_signed == OP_MULTU || !multiplicand[WIDTH-1]) ? multiplicand : -multiplicand;
  assign b_mag = (is_signed == OP_MULTU || !multiplier[WIDTH-1])   ? multiplier   : -multiplier;

  mult_step #(.WIDTH(WIDTH)) u_step (
    .prod_i  (prod_q),
    .mcand_i (mcand_q),
    .lsb_i   (mplier_q[0]),
    .prod_o  (step_prod)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        // MTHI/MTLO land even when start is taken in the same cycle; the
        // multiply result later overwrites them.
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = (is_signed == OP_MULT) & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          prod_d   = step_prod;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_d = FIXUP;
        end
      end
      FIXUP: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          {hi_d, lo_d} = neg_q ? -prod_q : prod_q;
          done_d       = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer: reset, MTHI/MTLO, unsigned/signed products,
// latency and done pulse, busy-time ignores, cancel and mid-op reset.
// Inputs driven on the falling edge, outputs sampled on the falling edge.
module tb_mult_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        cancel;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int pass_cnt  = 0;
  int check_cnt = 0;

  mult_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .is_signed    (is_signed),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .cancel       (cancel),
    .hi_we        (hi_we),
    .lo_we        (lo_we),
    .wdata        (wdata),
    .busy         (busy),
    .done         (done),
    .hi           (hi),
    .lo           (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue a one-cycle start (optionally with cancel) and wait for done.
  // Index i counts falling edges after the sampling edge T, starting at 0.
  task automatic run_mult(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic with_cancel,
                          output int nbusy, output int ndone, output logic got_done);
    nbusy = 0; ndone = -1; got_done = 1'b0;
    @(negedge clk);
    start = 1'b1; is_signed = s; multiplicand = a; multiplier = b; cancel = with_cancel;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        got_done = 1'b1;
        ndone = i;
        break;
      end
      if (busy) nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; is_signed = 0; multiplicand = 0; multiplier = 0;
    cancel = 0; hi_we = 0; lo_we = 0; wdata = 0;
    repeat (3) @(negedge clk);
    check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    check_cnt++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else pass_cnt++;
    check_cnt++; if (hi !== 32'h0) $display("FAIL reset_hi: got %h expected 00000000", hi); else pass_cnt++;
    check_cnt++; if (lo !== 32'h0) $display("FAIL reset_lo: got %h expected 00000000", lo); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mthi_mtlo();
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0; wdata = 32'h0;
    check_cnt++; if (hi !== 32'hDEADBEEF) $display("FAIL mt_hi: got %h expected deadbeef", hi); else pass_cnt++;
    check_cnt++; if (lo !== 32'hDEADBEEF) $display("FAIL mt_lo: got %h expected deadbeef", lo); else pass_cnt++;
    check_cnt++; if (done !== 1'b0) $display("FAIL mt_done: got %b expected 0", done); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL mt_busy: got %b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_unsigned_max();
    int nb, nd; logic gd;
    run_mult(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, nb, nd, gd);
    check_cnt++; if (!gd) $display("FAIL umax_done_seen: got 0 expected 1"); else pass_cnt++;
    check_cnt++; if (nd != 33) $display("FAIL umax_done_cycle: got %0d expected 33", nd); else pass_cnt++;
    check_cnt++; if (nb != 33) $display("FAIL umax_busy_cycles: got %0d expected 33", nb); else pass_cnt++;
    check_cnt++; if (busy !== 1'b0) $display("FAIL umax_busy_at_done: got %b expected 0", busy); else pass_cnt++;
    check_cnt++; if (hi !== 32'hFFFFFFFE) $display("FAIL umax_hi: got %h expected fffffffe", hi); else pass_cnt++;
    check_cnt++; if (lo !== 32'h00000001) $display("FAIL umax_lo: got %h expected 00000001", lo); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (done !== 1'b0) $display("FAIL umax_done_pulse: got %b expected 0", done); else pass_cnt++;
  endtask

  task automatic test_signed();
    int nb, nd; logic gd;
    run_mult(1'b1, 32'hFFFFFFFD, 32'd5, 1'b0, nb, nd, gd);
    check_cnt++; if (!gd || nd != 33) $display("FAIL s1_done_cycle: got %0d expected 33", nd); else pass_cnt++;
    check_cnt++; if (hi !== 32'hFFFFFFFF) $display("FAIL s1_hi: got %h expected ffffffff", hi); else pass_cnt++;
    check_cnt++; if (lo !== 32'hFFFFFFF1) $display("FAIL s1_lo: got %h expected fffffff1", lo); else pass_cnt++;
    run_mult(1'b1, 32'd7, 32'hFFFFFFFF, 1'b0, nb, nd, gd);
    check_cnt++; if (hi !== 32'hFFFFFFFF) $display("FAIL s2_hi: got %h expected ffffffff", hi); else pass_cnt++;
    check_cnt++; if (lo !== 32'hFFFFFFF9) $display("FAIL s2_lo: got %h expected fffffff9", lo); else pass_cnt++;
    // Both negative: product positive.
    run_mult(1'b1, 32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, nb, nd, gd);
    check_cnt++; if (hi !== 32'h0) $display("FAIL s3_hi: got %h expected 00000000", hi); else pass_cnt++;
    check_cnt++; if (lo !== 32'd6) $display("FAIL s3_lo: got %h expected 00000006", lo); else pass_cnt++;
  endtask

  task automatic test_min_corner();
    int nb, nd; logic gd;
    run_mult(1'b1, 32'h80000000, 32'h80000000, 1'b0, nb, nd, gd);
    check_cnt++; if (hi !== 32'h40000000) $display("FAIL mins_hi: got %h expected 40000000", hi); else pass_cnt++;
    check_cnt++; if (lo !== 32'h0) $display("FAIL mins_lo: got %h expected 00000000", lo); else pass_cnt++;
    run_mult(1'b0, 32'h80000000, 32'h80000000, 1'b0, nb, nd, gd);
    check_cnt++; if (hi !== 32'h40000000) $display("FAIL minu_hi: got %h expected 40000000", hi); else pass_cnt++;
    check_cnt++; if (lo !== 32'h0) $display("FAIL minu_lo: got %h expected 00000000", lo); else pass_cnt++;
  endtask

  task automatic test_busy_rules();
    int nd; logic gd;
    nd = -1; gd = 1'b0;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; multiplicand = 32'd3; multiplier = 32'd4;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (i == 10) begin
        start = 1'b1; multiplicand = 32'd100; multiplier = 32'd100;
        hi_we = 1'b1; wdata = 32'h1234;
      end else begin
        start = 1'b0; hi_we = 1'b0;
      end
      if (i == 12) begin
        check_cnt++; if (hi !== 32'h40000000) $display("FAIL busy_hi_hold: got %h expected 40000000", hi); else pass_cnt++;
      end
      if (done) begin
        gd = 1'b1; nd = i;
        break;
      end
      @(negedge clk);
    end
    check_cnt++; if (!gd || nd != 33) $display("FAIL busy_done_cycle: got %0d expected 33", nd); else pass_cnt++;
    check_cnt++; if (hi !== 32'h0) $display("FAIL busy_hi: got %h expected 00000000", hi); else pass_cnt++;
    check_cnt++; if (lo !== 32'd12) $display("FAIL busy_lo: got %h expected 0000000c", lo); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (busy !== 1'b0) $display("FAIL busy_no_queue: got %b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_cancel_reset();
    logic saw_done;
    hi_we = 1'b1; wdata = 32'hAAAA0000;
    @(negedge clk);
    hi_we = 1'b0;
    check_cnt++; if (hi !== 32'hAAAA0000) $display("FAIL cr_mthi: got %h expected aaaa0000", hi); else pass_cnt++;
    start = 1'b1; is_signed = 1'b0; multiplicand = 32'd7; multiplier = 32'd9;
    @(negedge clk);
    start = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 45; i++) begin
      cancel = (i == 5);
      if (i == 6) begin
        check_cnt++; if (busy !== 1'b0) $display("FAIL cancel_busy: got %b expected 0", busy); else pass_cnt++;
        check_cnt++; if (hi !== 32'hAAAA0000) $display("FAIL cancel_hi: got %h expected aaaa0000", hi); else pass_cnt++;
        check_cnt++; if (lo !== 32'd12) $display("FAIL cancel_lo: got %h expected 0000000c", lo); else pass_cnt++;
      end
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    cancel = 1'b0;
    check_cnt++; if (saw_done !== 1'b0) $display("FAIL cancel_no_done: got %b expected 0", saw_done); else pass_cnt++;

    start = 1'b1; multiplicand = 32'hFFFFFFFF; multiplier = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check_cnt++; if (busy !== 1'b1) $display("FAIL rst_pre_busy: got %b expected 1", busy); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    check_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy: got %b expected 0", busy); else pass_cnt++;
    check_cnt++; if (hi !== 32'h0) $display("FAIL rst_mid_hi: got %h expected 00000000", hi); else pass_cnt++;
    check_cnt++; if (lo !== 32'h0) $display("FAIL rst_mid_lo: got %h expected 00000000", lo); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) saw_done = 1'b1;
      @(negedge clk);
    end
    check_cnt++; if (saw_done !== 1'b0) $display("FAIL rst_quiet: got %b expected 0", saw_done); else pass_cnt++;
  endtask

  task automatic test_cancel_with_start();
    int nb, nd; logic gd;
    run_mult(1'b0, 32'd6, 32'd7, 1'b1, nb, nd, gd);
    check_cnt++; if (!gd || nd != 33) $display("FAIL cs_done_cycle: got %0d expected 33", nd); else pass_cnt++;
    check_cnt++; if (lo !== 32'd42) $display("FAIL cs_lo: got %h expected 0000002a", lo); else pass_cnt++;
    check_cnt++; if (hi !== 32'h0) $display("FAIL cs_hi: got %h expected 00000000", hi); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_unsigned_max();
    test_signed();
    test_min_corner();
    test_busy_rules();
    test_cancel_reset();
    test_cancel_with_start();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mult_sequencer.md
Name: mult_sequencer

Overview:
- Multi-cycle controller and HI/LO register owner for the CPU's MULT/MULTU instructions.
- Accepts a start request from the execute stage and runs a shift-add multiplication, one multiplier bit per clock.
- Signed operation uses a magnitude-multiply plus final negate.
- Holds the architectural HI/LO registers, with busy/done handshake, cancel, and MTHI/MTLO writes.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits, product is 2*WIDTH.
- CNT_W, 5, iteration counter width; must equal clog2(WIDTH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a multiply; sampled only in IDLE
- is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start
- multiplicand  input  WIDTH  operand A; sampled with start
- multiplier  input  WIDTH  operand B; sampled with start
- cancel  input  1  abort an in-flight multiply (pipeline flush)
- hi_we  input  1  MTHI write enable
- lo_we  input  1  MTLO write enable
- wdata  input  WIDTH  MTHI/MTLO data
- busy  output  1  operation in progress; execute stage stalls MFHI/MFLO/MULT while high
- done  output  1  one-cycle pulse: HI/LO were just updated by a multiply
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; hi=0, lo=0, busy=0, done=0; counter, product and operand registers=0.
- States:
  - IDLE: busy=0.
    - start=1 at edge T: latch |A|, |B| (magnitudes if is_signed, raw otherwise) and neg = is_signed & (A[WIDTH-1]^B[WIDTH-1]); clear product and counter; go to CALC.
    - |x| of 0x80000000 is 0x80000000 read as unsigned; no overflow case.
  - CALC: busy=1; one iteration per edge, WIDTH edges (T+1..T+WIDTH), counter 0..WIDTH-1.
    - Each iteration: if the current multiplier LSB is 1, upper half = upper half + |A|, with the carry kept as bit 2*WIDTH.
    - Then shift {carry, product} right 1 and shift the multiplier right 1.
    - After counter = WIDTH-1 go to FIXUP.
  - FIXUP: busy=1; at edge T+WIDTH+1, {hi,lo} <= neg ? -product : product (64-bit two's-complement negate); done<=1; go to IDLE.
- Latency: start sampled at edge T means busy=1 from T to T+WIDTH+1; done=1 and hi/lo valid during the single cycle after edge T+WIDTH+1 (T+33 for WIDTH=32). busy falls on the same edge done rises.
- done is high for exactly one cycle and is never asserted on the cancel path.
- start while busy: ignored; no queueing. Operands are not re-sampled mid-operation.
- cancel while busy: next edge returns to IDLE, busy=0, hi/lo unchanged, done stays 0. cancel in IDLE has no effect.
- cancel and start together in IDLE: start accepted; cancel ignored.
- hi_we/lo_we in IDLE: write wdata at that edge; both may be written in the same cycle.
- hi_we/lo_we while busy: ignored; the pending multiply result is authoritative.
- hi_we and start in the same IDLE cycle: the write takes effect at T and is overwritten by the result at T+33.
- Reset mid-operation: immediate abort to the reset values; no done.
- hi/lo change only on a FIXUP edge, an accepted IDLE write, or reset.

Decomposition:
- Shared package mult_pkg:
  - state enum {IDLE, CALC, FIXUP}
  - WIDTH default
  - op encoding constants OP_MULTU=0, OP_MULT=1, matching the is_signed bit
- One natural sub-module: mult_step. It is combinational: given product, multiplicand and multiplier LSB, it returns the next shifted product.
- The sequencer keeps the FSM, counter, sign fixup and HI/LO.

Test Plan:
- Unsigned max: start, is_signed=0, A=B=0xFFFFFFFF → busy 33 cycles; done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- Signed mixed sign: is_signed=1, A=0xFFFFFFFD (-3), B=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. Repeat A=7, B=0xFFFFFFFF → hi=0xFFFFFFFF, lo=0xFFFFFFF9.
- Signed min corner: is_signed=1, A=B=0x80000000 → hi=0x40000000, lo=0x00000000. As MULTU the same operands → identical result.
- Busy rules: start a multiply; at cycle 10 assert start with new operands and hi_we with wdata=0x1234 → both ignored; the first result appears at cycle 33.
- Cancel and reset: set hi=0xAAAA0000 via hi_we in IDLE; start; cancel at cycle 5 → busy=0 next cycle, no done, hi=0xAAAA0000. Start again; pull rst_n low at cycle 20 → hi=lo=0, busy=0 immediately.
- MTHI/MTLO: in IDLE write hi_we=1 and lo_we=1 with wdata=0xDEADBEEF in one cycle → hi=lo=0xDEADBEEF, done stays 0.
